// File: rtl/jtframe_joyser_tx.sv
// Device end of the serial joystick link: emulates the 74HC165 chain that
// shifts two 6-bit pad states out to the host on joy_data.
module jtframe_joyser_tx #(
    parameter int TOW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] joy1,
    input  logic [5:0] joy2,
    input  logic       joy_clk,
    input  logic       joy_load,
    output logic       joy_data,
    output logic       frame_done,
    output logic       link_ok
);

    localparam int NUM_PADS = 2;

    logic [1:0]     clk_sync, load_sync;
    logic           clk_prev, load_prev;
    logic           clk_rise, load_low, load_fall;
    logic [15:0]    sr;
    logic [4:0]     cnt;
    logic           done_p;
    logic [TOW-1:0] to;

    logic [NUM_PADS-1:0][5:0] joy;
    logic [NUM_PADS-1:0][7:0] frame_byte;

    // Host strobes are asynchronous; flops idle high like the idle link
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            load_sync <= '1;
            clk_prev  <= 1'b1;
            load_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], joy_clk};
            load_sync <= {load_sync[0], joy_load};
            clk_prev  <= clk_sync[1];
            load_prev <= load_sync[1];
        end
    end

    assign clk_rise  = clk_sync[1] & ~clk_prev;
    assign load_low  = ~load_sync[1];
    assign load_fall = load_low & load_prev;

    assign joy = {joy1, joy2};

    // Adapter board wiring order, pressed = 0, two unused inputs tied high
    genvar p;
    generate
        for (p = 0; p < NUM_PADS; p++) begin : g_pad
            assign frame_byte[p] = {~joy[p][3], ~joy[p][2], ~joy[p][1], ~joy[p][0],
                                    ~joy[p][4], ~joy[p][5], 2'b11};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= 16'hFFFF;
            cnt    <= 5'd0;
            done_p <= 1'b0;
        end else if (load_low) begin
            sr     <= frame_byte;
            cnt    <= 5'd0;
            done_p <= 1'b0;
        end else if (clk_rise) begin
            sr     <= {sr[14:0], 1'b1};
            cnt    <= (cnt == 5'd16) ? cnt : cnt + 5'd1;
            done_p <= (cnt == 5'd15);
        end else begin
            done_p <= 1'b0;
        end
    end

    // done_p is delayed one cycle so the pulse lines up with joy_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            joy_data   <= sr[15];
            frame_done <= done_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to      <= '0;
            link_ok <= 1'b0;
        end else begin
            if (load_fall)
                to <= '0;
            else if (to != '1)
                to <= to + TOW'(1);
            // a stale link never reports ok, even if a frame just ended
            if (to == '1)
                link_ok <= 1'b0;
            else if (frame_done)
                link_ok <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtframe_joyser_tx.sv
// Bench for jtframe_joyser_tx: per-cycle comparison against a frame-level
// model plus literal checks of captured serial streams.
module tb_jtframe_joyser_tx;

    localparam int TOW   = 9;
    localparam int TOMAX = (1 << TOW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] joy1 = 6'd0, joy2 = 6'd0;
    logic       joy_clk = 1'b0, joy_load = 1'b1;
    logic       joy_data, frame_done, link_ok;

    int          tests = 0, errs = 0, fd_cnt = 0;
    int unsigned cyc = 0;

    jtframe_joyser_tx #(.TOW(TOW)) dut (
        .clk(clk), .rst_n(rst_n), .joy1(joy1), .joy2(joy2),
        .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data), .frame_done(frame_done), .link_ok(link_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [5:0] a, input logic [5:0] b);
        logic [15:0] w;
        int order [6];
        order = '{3, 2, 1, 0, 4, 5};
        w = 16'hFFFF;
        for (int k = 0; k < 6; k++) begin
            w[15-k] = ~a[order[k]];
            w[7-k]  = ~b[order[k]];
        end
        return w;
    endfunction

    // Model: frame position and latched word; host strobes seen through a
    // three-sample history to account for the synchroniser delay.
    logic [2:0]  jc_h, jl_h;
    int unsigned m_pos, m_to;
    logic [15:0] m_word;
    logic        m_dp, m_data, m_fd, m_link;

    always @(posedge clk or negedge rst_n) begin
        logic rise, ld, lf;
        if (!rst_n) begin
            jc_h = 3'b111; jl_h = 3'b111;
            m_pos = 0; m_word = 16'hFFFF; m_dp = 1'b0;
            m_data = 1'b1; m_fd = 1'b0; m_link = 1'b0; m_to = 0;
        end else begin
            rise = jc_h[1] & ~jc_h[2];
            ld   = ~jl_h[1];
            lf   = ld & jl_h[2];
            m_link = (m_to == TOMAX) ? 1'b0 : (m_fd ? 1'b1 : m_link);
            m_fd   = m_dp;
            m_data = (m_pos >= 16) ? 1'b1 : m_word[15-m_pos];
            m_to   = lf ? 0 : ((m_to == TOMAX) ? m_to : m_to + 1);
            if (ld) begin
                m_word = word_of(joy1, joy2);
                m_pos  = 0;
                m_dp   = 1'b0;
            end else if (rise) begin
                m_dp  = (m_pos == 15);
                m_pos = (m_pos >= 16) ? 16 : m_pos + 1;
            end else begin
                m_dp = 1'b0;
            end
            jc_h = {jc_h[1:0], joy_clk};
            jl_h = {jl_h[1:0], joy_load};
        end
    end

    always @(negedge clk) begin
        chk("model_joy_data",   32'(joy_data),   32'(m_data));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
        chk("model_link_ok",    32'(link_ok),    32'(m_link));
        if (frame_done) fd_cnt++;
    end

    // One host poll: load held 8 cycles, then nclk clocks of 8-cycle halves.
    task automatic frame(input logic [5:0] a, input logic [5:0] b, input int nclk,
                         output logic [15:0] cap, output logic extra_ones,
                         output int unsigned load_cyc);
        joy1 = a; joy2 = b;
        cap = 16'hFFFF; extra_ones = 1'b1;
        load_cyc = cyc;
        joy_load = 1'b0;
        repeat (8) @(negedge clk);
        cap[15] = joy_data;
        joy_load = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            joy_clk = 1'b1;
            repeat (8) @(negedge clk);
            joy_clk = 1'b0;
            repeat (6) @(negedge clk);
            if (i < 15) cap[14-i] = joy_data;
            else        extra_ones = extra_ones & joy_data;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cap;
        logic        ones;
        int unsigned lc;
        int          fd0;

        // reset with random activity on every input
        repeat (6) begin
            @(negedge clk);
            joy1 = 6'($urandom); joy2 = 6'($urandom);
            joy_clk = 1'($urandom); joy_load = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_joy_data", 32'(joy_data), 1);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_link_ok", 32'(link_ok), 0);
        joy_clk = 1'b0; joy_load = 1'b1; joy1 = 6'd0; joy2 = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_joy_data", 32'(joy_data), 1);
        chk("idle_link_ok", 32'(link_ok), 0);

        // transparent load tracks joy1 while load stays low
        joy1 = 6'b001000; joy_load = 1'b0;
        repeat (8) @(negedge clk);
        chk("load_track_up", 32'(joy_data), 0);
        joy1 = 6'b000000;
        repeat (5) @(negedge clk);
        chk("load_track_release", 32'(joy_data), 1);
        joy_load = 1'b1;
        repeat (8) @(negedge clk);

        fd0 = fd_cnt;
        frame(6'b001000, 6'b000000, 16, cap, ones, lc);
        repeat (8) @(negedge clk);
        chk("single_stream", 32'(cap), 32'h7FFF);
        chk("single_done_cnt", fd_cnt - fd0, 1);
        chk("single_link_ok", 32'(link_ok), 1);

        fd0 = fd_cnt;
        frame(6'b110001, 6'b000110, 16, cap, ones, lc);
        repeat (8) @(negedge clk);
        chk("mixed_stream", 32'(cap), 32'hE39F);
        chk("mixed_done_cnt", fd_cnt - fd0, 1);

        fd0 = fd_cnt;
        frame(6'b111111, 6'b101010, 5, cap, ones, lc);
        chk("abort_first_bits", 32'(cap[15:10]), 0);
        frame(6'b000000, 6'b000000, 16, cap, ones, lc);
        repeat (8) @(negedge clk);
        chk("abort_restart_stream", 32'(cap), 32'hFFFF);
        chk("abort_done_cnt", fd_cnt - fd0, 1);

        fd0 = fd_cnt;
        frame(6'b010101, 6'b100000, 20, cap, ones, lc);
        repeat (8) @(negedge clk);
        chk("over_stream", 32'(cap), 32'hA7FB);
        chk("over_extra_ones", 32'(ones), 1);
        chk("over_done_cnt", fd_cnt - fd0, 1);
        chk("over_link_ok", 32'(link_ok), 1);

        // watchdog: load low driven at lc, cleared 515 cycles later
        for (int k = 0; k < 2000 && link_ok; k++) @(negedge clk);
        chk("timeout_link_low", 32'(link_ok), 0);
        chk("timeout_delay", cyc - lc, 515);
        repeat (50) @(negedge clk);
        chk("timeout_stays_low", 32'(link_ok), 0);

        fd0 = fd_cnt;
        frame(6'b000000, 6'b000000, 16, cap, ones, lc);
        repeat (8) @(negedge clk);
        chk("recover_link_ok", 32'(link_ok), 1);
        chk("recover_done_cnt", fd_cnt - fd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/jtframe_joyser_tx.md
# jtframe_joyser_tx

Serial joystick transmitter: the device end of the NeptUNO / MC2+ serial joystick link whose host end is `joystick_serial`. It samples the host-driven `joy_clk` / `joy_load` strobes and shifts two 6-bit joystick states out on `joy_data`, emulating the 74HC165 chain on the joystick adapter board. Used in simulation benches of the NeptUNO top and in cores that relay pad state to a second board over the same three-wire link.

## Interface

Parameters:
- `TOW`, default 16: width of the link-timeout counter; timeout is 2^TOW−1 `clk` cycles without a load.

Ports:
- `clk`  in  1  system clock; all logic is on this clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `joy1`  in  6  player 1 state, active high: [5] fire2, [4] fire1, [3] up, [2] down, [1] left, [0] right.
- `joy2`  in  6  player 2 state, same layout as `joy1`.
- `joy_clk`  in  1  host shift clock; asynchronous to `clk`.
- `joy_load`  in  1  host parallel-load strobe, active low; asynchronous to `clk`.
- `joy_data`  out  1  serial data to host; pressed button = 0.
- `frame_done`  out  1  one-cycle pulse when the 16th bit has been shifted.
- `link_ok`  out  1  high while the host is polling regularly.

## Operation

- Synchronisers: `joy_clk` and `joy_load` each pass through 2 flops (reset value 1), then a third flop for edge detection. `clk_rise` = sync high and previous low; `load_low` = synced load level 0; `load_fall` = synced falling edge.
- Frame word, MSB shifted first, 16 bits: {~joy1[3], ~joy1[2], ~joy1[1], ~joy1[0], ~joy1[4], ~joy1[5], 1, 1, ~joy2[3], ~joy2[2], ~joy2[1], ~joy2[0], ~joy2[4], ~joy2[5], 1, 1}.
- Shift register `sr` (16 bits) and bit counter `cnt` (0..16, 5 bits):
  - `load_low`: `sr` <= frame word every cycle (transparent load); `cnt` <= 0. Any in-progress frame is aborted with no `frame_done`.
  - Otherwise, on `clk_rise`: `sr` <= {sr[14:0], 1'b1}; `cnt` <= `cnt`+1, saturating at 16.
  - `load_low` together with `clk_rise`: load wins and the shift is ignored.
- `joy_data` is registered from `sr[15]`. While load is held low it tracks the current frame MSB. Once 16 shifts have occurred it reads 1 indefinitely.
- `frame_done` pulses for exactly one cycle on the `clk_rise` that moves `cnt` from 15 to 16. Extra clocks beyond 16 produce no further pulses.
- Link watchdog, counter `to` of TOW bits:
  - `to` <= 0 on `load_fall`; otherwise increments, saturating at all-ones.
  - `link_ok` is set on `frame_done` and cleared when `to` reaches all-ones.
  - Reset mid-frame: everything returns to its reset values immediately, asynchronously.

## Timing

- Reset values: `sr`=16'hFFFF, `cnt`=0, `joy_data`=1, `frame_done`=0, `link_ok`=0, `to`=0, all synchroniser flops=1.
- Latency: an external `joy_clk` rising edge reaches `joy_data` after 4 `clk` edges (2 sync, 1 edge detect, 1 output register). An external `joy_load` low reaches `joy_data` with the same latency.
- Host constraint: `joy_clk` high and low phases must each be ≥4 `clk` cycles, and `joy_load` low must be ≥4 `clk` cycles. Shorter pulses may be missed; no glitch filtering is done.
- `joy1`/`joy2` are sampled on every cycle of `load_low`. The last sample before load rises is the one transmitted.
- `frame_done` is asserted in the same cycle that `joy_data` presents the post-frame 1, one cycle after `cnt` reaches 16.

## Test plan

- Reset: hold `rst_n`=0 with random inputs -> `joy_data`=1, `frame_done`=0, `link_ok`=0. Release -> the outputs stay at these values until the first load.
- Single frame: `joy1`=6'b001000 (up), `joy2`=0; pulse load low for 8 cycles, then 16 clocks of 8-cycle half period. Sample at 6 cycles after each falling edge -> bits 0111_1111_1111_1111. `frame_done` pulses once. `link_ok` rises.
- Mixed buttons: `joy1`=6'b110001, `joy2`=6'b000110 -> serial stream 1110_0011_1001_1111.
- Aborted frame: after 5 shifts, pulse load low again with `joy1`=0 -> the stream restarts at MSB with all 1s. No `frame_done` for the aborted frame.
- Overshift: 20 clocks after load -> bits 17..20 read 1. Exactly one `frame_done`.
- Timeout, with TOW=6: complete one frame, then no load -> `link_ok` falls 63 cycles after the last `load_fall`. The next completed frame sets `link_ok` again.
